// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data RAM serving Data_path's load/store port.
// One access at a time: IDLE captures a request, WAIT burns WAIT_CYCLES wait
// states, RESP pulses ready for one cycle with load data or store completion.
// Optional build macro: MISALIGN_CHECK_EN flags non-word-aligned accesses with err
// and suppresses their effect; when undefined, addr[1:0] is ignored and err is 0.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          align_q, align_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                store_q, store_d;
  logic                busy_q, busy_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  // Access attributes as seen on the edge entering RESP: live inputs when the
  // response follows capture directly (zero wait states), latched copies otherwise.
  logic [ADDR_W-1:0]   acc_idx;
  logic [1:0]          acc_align;
  logic [31:0]         acc_wdata;
  logic [3:0]          acc_be;
  logic                acc_store;
  logic                misalign;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_idx;
  logic [31:0]         wr_data;
  logic [3:0]          wr_be;

  logic [31:0]         ram [DEPTH];

  // Upper address bits alias onto the RAM and are deliberately not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Select live request inputs in IDLE, the captured request in WAIT/RESP.
  always_comb begin
    acc_idx   = idx_q;
    acc_align = align_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    acc_store = store_q;
    if (state_q == S_IDLE) begin
      acc_idx   = addr[ADDR_W+1:2];
      acc_align = addr[1:0];
      acc_wdata = wdata;
      acc_be    = be;
      acc_store = mem_w;
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign misalign = (acc_align != 2'b00);
`else
  logic unused_align;
  assign unused_align = ^acc_align;
  assign misalign = 1'b0;
`endif

  // State and datapath registers; RAM contents live in a separate unreset array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      align_q <= 2'b00;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      store_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      align_q <= align_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      store_q <= store_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the RAM write and load capture both happen on the edge entering RESP.
  always_comb begin
    logic enter_resp;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    align_d    = align_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    store_d    = store_q;
    busy_d     = busy_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = acc_idx;
    wr_data    = acc_wdata;
    wr_be      = acc_be;

    case (state_q)
      S_IDLE: begin
        if (mem_r || mem_w) begin
          idx_d   = addr[ADDR_W+1:2];
          align_d = addr[1:0];
          wdata_d = wdata;
          be_d    = be;
          store_d = mem_w;
          busy_d  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase

    if (enter_resp) begin
      err_d = misalign;
      if (!misalign) begin
        if (acc_store) begin
          wr_en = 1'b1;
        end else begin
          rdata_d = ram[acc_idx];
        end
      end
    end
  end

  // Byte-masked RAM write; held off while reset is asserted so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          ram[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == S_RESP);
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (ADDR_W=8, WAIT_CYCLES=2).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int tests_run;
  int tests_failed;

  // Results of the most recent single access
  int          acc_lat;
  int          acc_extra;
  logic [31:0] acc_rdata;
  logic        acc_err;
  logic        acc_busy_first;
  logic        acc_busy_after;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .mem_r (mem_r),
    .mem_w (mem_w),
    .addr  (addr),
    .wdata (wdata),
    .be    (be),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, wait (bounded) for ready, drop the request and watch for stray pulses.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    logic got;
    @(negedge clk);
    mem_r = r; mem_w = w; addr = a; wdata = d; be = b;
    acc_lat = 0; got = 1'b0; acc_busy_first = 1'b0;
    acc_rdata = 32'hx; acc_err = 1'bx;
    while (!got && acc_lat < 20) begin
      @(negedge clk);
      acc_lat++;
      if (acc_lat == 1) acc_busy_first = busy;
      if (ready) begin
        got = 1'b1;
        acc_rdata = rdata;
        acc_err = err;
      end
    end
    mem_r = 1'b0; mem_w = 1'b0;
    acc_extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) acc_extra++;
    end
    acc_busy_after = busy;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1; mem_r = 1'b0; mem_w = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    @(negedge clk);
    tests_run++;
    if (rdata !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 32'd0); end
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || ready !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_quiet: got activity %b expected 0", seen); end
  endtask

  task automatic test_store_load();
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    tests_run++;
    if (acc_lat != 3) begin tests_failed++; $display("[TB] FAIL store_latency: got %0d expected 3", acc_lat); end
    tests_run++;
    if (acc_busy_first !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_busy: got %b expected 1", acc_busy_first); end
    tests_run++;
    if (acc_extra != 0) begin tests_failed++; $display("[TB] FAIL store_single_pulse: got %0d extra expected 0", acc_extra); end
    tests_run++;
    if (acc_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL store_err: got %b expected 0", acc_err); end
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000);
    tests_run++;
    if (acc_lat != 3) begin tests_failed++; $display("[TB] FAIL load_latency: got %0d expected 3", acc_lat); end
    tests_run++;
    if (acc_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL load_data: got %h expected %h", acc_rdata, 32'hDEADBEEF); end
    tests_run++;
    if (acc_busy_after !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_release: got %b expected 0", acc_busy_after); end
    tests_run++;
    if (rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL rdata_hold: got %h expected %h", rdata, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_enable();
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h00000000, 4'b1111);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);
    tests_run++;
    if (acc_rdata !== 32'h00BB00DD) begin tests_failed++; $display("[TB] FAIL byte_enable: got %h expected %h", acc_rdata, 32'h00BB00DD); end
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    tests_run++;
    if (acc_lat != 3) begin tests_failed++; $display("[TB] FAIL be_zero_latency: got %0d expected 3", acc_lat); end
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);
    tests_run++;
    if (acc_rdata !== 32'h00BB00DD) begin tests_failed++; $display("[TB] FAIL be_zero_nowrite: got %h expected %h", acc_rdata, 32'h00BB00DD); end
  endtask

  task automatic test_wrap();
    applyStimulus(1'b0, 1'b1, 32'h400, 32'h12345678, 4'b1111);
    applyStimulus(1'b1, 1'b0, 32'h000, 32'h0, 4'b1111);
    tests_run++;
    if (acc_rdata !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL addr_wrap: got %h expected %h", acc_rdata, 32'h12345678); end
  endtask

  task automatic test_rw_priority();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'b1111);
    tests_run++;
    if (acc_extra != 0 || acc_lat != 3) begin tests_failed++; $display("[TB] FAIL rw_one_pulse: got lat %0d extra %0d expected lat 3 extra 0", acc_lat, acc_extra); end
    tests_run++;
    if (acc_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL rw_rdata_unchanged: got %h expected %h", acc_rdata, 32'hDEADBEEF); end
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'b0000);
    tests_run++;
    if (acc_rdata !== 32'h5A5A5A5A) begin tests_failed++; $display("[TB] FAIL rw_store_wins: got %h expected %h", acc_rdata, 32'h5A5A5A5A); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] mask;
    @(negedge clk);
    mem_r = 1'b1; mem_w = 1'b0; addr = 32'h10; wdata = 32'h0; be = 4'b0000;
    mask = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ready) mask[k] = 1'b1;
    end
    mem_r = 1'b0;
    tests_run++;
    if (mask !== 9'h088) begin tests_failed++; $display("[TB] FAIL back_to_back: got ready mask %h expected %h", mask, 9'h088); end
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    logic seen;
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h11111111, 4'b1111);
    @(negedge clk);
    mem_w = 1'b1; addr = 32'h40; wdata = 32'h22222222; be = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_outputs: got busy %b ready %b expected 0 0", busy, ready); end
    @(negedge clk);
    rst = 1'b0; mem_w = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_no_ready: got %b expected 0", seen); end
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000);
    tests_run++;
    if (acc_rdata !== 32'h11111111) begin tests_failed++; $display("[TB] FAIL abort_no_commit: got %h expected %h", acc_rdata, 32'h11111111); end
  endtask

  task automatic test_misalign();
    applyStimulus(1'b0, 1'b1, 32'h41, 32'h33333333, 4'b1111);
`ifdef MISALIGN_CHECK_EN
    tests_run++;
    if (acc_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL misalign_err: got %b expected 1", acc_err); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL misalign_err_clear: got %b expected 0", err); end
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000);
    tests_run++;
    if (acc_rdata !== 32'h11111111) begin tests_failed++; $display("[TB] FAIL misalign_suppress: got %h expected %h", acc_rdata, 32'h11111111); end
`else
    tests_run++;
    if (acc_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL unaligned_err: got %b expected 0", acc_err); end
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000);
    tests_run++;
    if (acc_rdata !== 32'h33333333) begin tests_failed++; $display("[TB] FAIL unaligned_store: got %h expected %h", acc_rdata, 32'h33333333); end
`endif
    tests_run++;
    if (acc_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL aligned_load_err: got %b expected 0", acc_err); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_wrap();
    test_rw_priority();
    test_back_to_back();
    test_reset_abort();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
